vospi_frame_ctrl: RTL and testbench

Sequences the VoSPI byte-stream receiver and runs one capture session per enable. Holds the receiver in reset, releases it, and issues its start pulse. Assembles the receiver's valid payload bytes into 16-bit pixels and writes them into a ping-pong frame buffer, then hands completed frames to a downstream consumer with a valid/ack handshake. A watchdog restarts the receiver when the stream stalls.

---
 rtl/vospi_pkg.sv | 22 ++
 rtl/vospi_pixel_pack.sv | 45 ++++
 rtl/vospi_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_vospi_frame_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/vospi_pkg.sv
// Shared types and frame geometry for the VoSPI capture path.
package vospi_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRestart = 3'd1,
    StStart   = 3'd2,
    StCapture = 3'd3,
    StCommit  = 3'd4
  } vospi_state_e;

  localparam int unsigned VospiPacketBytes = 164;
  localparam int unsigned VospiHeaderBytes = 4;
  // Each packet carries one line of 16-bit pixels after its header.
  localparam int unsigned VospiCols = (VospiPacketBytes - VospiHeaderBytes) / 2;
  localparam int unsigned VospiRows = 60;

  function automatic int unsigned pixel_count(input int unsigned cols, input int unsigned rows);
    return cols * rows;
  endfunction

endpackage

// File: rtl/vospi_pixel_pack.sv
// Pairs receiver payload bytes into 16-bit pixels, first byte in the MSB.
module vospi_pixel_pack (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        flush_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        phase_o,
  output logic        pix_valid_o,
  output logic [15:0] pix_data_o
);

  logic        phase_q;
  logic [7:0]  msb_q;
  logic        valid_q;
  logic [15:0] pix_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q <= 1'b0;
      msb_q   <= 8'h00;
      valid_q <= 1'b0;
      pix_q   <= 16'h0000;
    end else if (flush_i) begin
      // Drop any half-assembled pixel; last pixel data is simply held.
      phase_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid_i && phase_q;
      if (byte_valid_i) begin
        if (phase_q) begin
          pix_q <= {msb_q, byte_i};
        end else begin
          msb_q <= byte_i;
        end
        phase_q <= ~phase_q;
      end
    end
  end

  assign phase_o     = phase_q;
  assign pix_valid_o = valid_q;
  assign pix_data_o  = pix_q;

endmodule

// File: rtl/vospi_frame_ctrl.sv
// Sequences the VoSPI receiver, packs pixels into a ping-pong frame buffer and
// hands finished frames to a consumer via valid/ack.
module vospi_frame_ctrl
  import vospi_pkg::*;
#(
  parameter int unsigned frame_cols_p     = VospiCols,
  parameter int unsigned frame_rows_p     = VospiRows,
  parameter int unsigned reset_cycles_p   = 16,
  parameter int unsigned timeout_cycles_p = 10000000
) (
  input  logic                                          clk_i,
  input  logic                                          reset_ni,
  input  logic                                          enable_i,
  output logic                                          mst_reset_o,
  output logic                                          mst_start_o,
  input  logic [7:0]                                    mst_data_i,
  input  logic                                          mst_valid_i,
  output logic                                          wr_en_o,
  output logic [$clog2(frame_cols_p*frame_rows_p):0]    wr_addr_o,
  output logic [15:0]                                   wr_data_o,
  output logic                                          frame_valid_o,
  output logic                                          rd_bank_o,
  input  logic                                          frame_ack_i,
  output logic [7:0]                                    frames_dropped_o,
  output logic [7:0]                                    timeouts_o
);

  localparam int unsigned NumPix = pixel_count(frame_cols_p, frame_rows_p);
  localparam int unsigned IdxW   = $clog2(NumPix);
  localparam int unsigned RstW   = (reset_cycles_p > 1) ? $clog2(reset_cycles_p) : 1;
  localparam int unsigned WdW    = $clog2(timeout_cycles_p + 1);

  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumPix - 1);
  localparam logic [RstW-1:0] RstLast = RstW'(reset_cycles_p - 1);
  localparam logic [WdW-1:0]  WdLast  = WdW'(timeout_cycles_p - 1);

  vospi_state_e    state_q, state_d;
  logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic [IdxW-1:0] pix_idx_q, pix_idx_d;
  logic            wr_bank_q, wr_bank_d;
  logic [IdxW:0]   wr_addr_q, wr_addr_d;
  logic            frame_valid_q, frame_valid_d;
  logic            rd_bank_q, rd_bank_d;
  logic [7:0]      drops_q, drops_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            mst_reset_q, mst_reset_d;
  logic            mst_start_q, mst_start_d;

  logic active, timeout_hit, flush, wr_fire, ack_ok, pack_phase;

  vospi_pixel_pack u_pack (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .flush_i      (flush),
    .byte_valid_i (mst_valid_i),
    .byte_i       (mst_data_i),
    .phase_o      (pack_phase),
    .pix_valid_o  (wr_en_o),
    .pix_data_o   (wr_data_o)
  );

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = '0;
    wdog_d        = '0;
    pix_idx_d     = pix_idx_q;
    wr_bank_d     = wr_bank_q;
    wr_addr_d     = wr_addr_q;
    frame_valid_d = frame_valid_q;
    rd_bank_d     = rd_bank_q;
    drops_d       = drops_q;
    tmo_d         = tmo_q;

    active      = (state_q == StCapture) || (state_q == StCommit);
    timeout_hit = active && enable_i && !mst_valid_i && (wdog_q == WdLast);
    flush       = !active || !enable_i || timeout_hit;
    wr_fire     = !flush && mst_valid_i && pack_phase;
    ack_ok      = frame_ack_i && frame_valid_q;

    // Ack is resolved before the commit so a same-cycle ack frees the slot.
    if (ack_ok) begin
      frame_valid_d = 1'b0;
    end
    if (state_q == StCommit) begin
      if (!frame_valid_d) begin
        rd_bank_d     = wr_bank_q;
        frame_valid_d = 1'b1;
        wr_bank_d     = ~wr_bank_q;
      end else if (drops_q != 8'hff) begin
        drops_d = drops_q + 8'd1;
      end
    end

    if (active) begin
      wdog_d = mst_valid_i ? '0 : wdog_q + 1'b1;
    end
    if (!active) begin
      pix_idx_d = '0;
    end
    if (wr_fire) begin
      wr_addr_d = {wr_bank_d, pix_idx_q};
      pix_idx_d = (pix_idx_q == IdxLast) ? '0 : pix_idx_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StRestart;
        end
      end
      StRestart: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StStart;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StStart: state_d = StCapture;
      StCapture, StCommit: begin
        if (timeout_hit) begin
          state_d = StRestart;
          if (tmo_q != 8'hff) begin
            tmo_d = tmo_q + 8'd1;
          end
        end else if (wr_fire && (pix_idx_q == IdxLast)) begin
          state_d = StCommit;
        end else begin
          state_d = StCapture;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable_i) begin
      state_d = StIdle;
    end

    mst_reset_d = (state_d == StIdle) || (state_d == StRestart);
    mst_start_d = (state_d == StStart);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      rst_cnt_q     <= '0;
      wdog_q        <= '0;
      pix_idx_q     <= '0;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      frame_valid_q <= 1'b0;
      rd_bank_q     <= 1'b0;
      drops_q       <= 8'h00;
      tmo_q         <= 8'h00;
      mst_reset_q   <= 1'b1;
      mst_start_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      wdog_q        <= wdog_d;
      pix_idx_q     <= pix_idx_d;
      wr_bank_q     <= wr_bank_d;
      wr_addr_q     <= wr_addr_d;
      frame_valid_q <= frame_valid_d;
      rd_bank_q     <= rd_bank_d;
      drops_q       <= drops_d;
      tmo_q         <= tmo_d;
      mst_reset_q   <= mst_reset_d;
      mst_start_q   <= mst_start_d;
    end
  end

  assign mst_reset_o      = mst_reset_q;
  assign mst_start_o      = mst_start_q;
  assign wr_addr_o        = wr_addr_q;
  assign frame_valid_o    = frame_valid_q;
  assign rd_bank_o        = rd_bank_q;
  assign frames_dropped_o = drops_q;
  assign timeouts_o       = tmo_q;

endmodule

// File: tb/tb_vospi_frame_ctrl.sv
// Directed vector bench for vospi_frame_ctrl with a 4x2 frame geometry.
module tb_vospi_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        enable_i;
  logic        mst_reset_o, mst_start_o;
  logic [7:0]  mst_data_i;
  logic        mst_valid_i;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic        frame_valid_o, rd_bank_o, frame_ack_i;
  logic [7:0]  frames_dropped_o, timeouts_o;

  always #5 clk = ~clk;

  vospi_frame_ctrl #(
    .frame_cols_p     (4),
    .frame_rows_p     (2),
    .reset_cycles_p   (4),
    .timeout_cycles_p (20)
  ) dut (
    .clk_i            (clk),
    .reset_ni         (reset_ni),
    .enable_i         (enable_i),
    .mst_reset_o      (mst_reset_o),
    .mst_start_o      (mst_start_o),
    .mst_data_i       (mst_data_i),
    .mst_valid_i      (mst_valid_i),
    .wr_en_o          (wr_en_o),
    .wr_addr_o        (wr_addr_o),
    .wr_data_o        (wr_data_o),
    .frame_valid_o    (frame_valid_o),
    .rd_bank_o        (rd_bank_o),
    .frame_ack_i      (frame_ack_i),
    .frames_dropped_o (frames_dropped_o),
    .timeouts_o       (timeouts_o)
  );

  typedef struct {
    string       tag;
    logic        en, vld, ack;
    logic [7:0]  dat;
    logic        rst, st, we, fv, rb;
    logic [3:0]  addr;
    logic [15:0] wd;
    logic [7:0]  drop, tmo;
  } vec_t;

  vec_t  vecs[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  string cur_tag;
  logic       ex_fv = 1'b0, ex_rb = 1'b0;
  logic [7:0] ex_drop = 8'd0, ex_tmo = 8'd0;

  task automatic add(input logic en, input logic vld, input logic [7:0] dat, input logic ack,
                     input logic rst, input logic st, input logic we, input logic [3:0] addr,
                     input logic [15:0] wd);
    vec_t v;
    v.tag = cur_tag; v.en = en; v.vld = vld; v.dat = dat; v.ack = ack;
    v.rst = rst; v.st = st; v.we = we; v.addr = addr; v.wd = wd;
    v.fv = ex_fv; v.rb = ex_rb; v.drop = ex_drop; v.tmo = ex_tmo;
    vecs.push_back(v);
  endtask

  task automatic idle(input logic ack);
    add(1'b1, 1'b0, 8'h00, ack, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic pix(input logic [3:0] addr, input logic [15:0] d);
    add(1'b1, 1'b1, d[15:8], 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    add(1'b1, 1'b1, d[7:0], 1'b0, 1'b0, 1'b0, 1'b1, addr, d);
  endtask

  // Four reset cycles, one start pulse, first capture cycle.
  task automatic seq_start();
    for (int i = 0; i < 4; i++) add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0);
    idle(1'b0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " mst_reset"}, 32'(mst_reset_o), 32'd1);
    chk({nm, " mst_start"}, 32'(mst_start_o), 32'd0);
    chk({nm, " wr_en"}, 32'(wr_en_o), 32'd0);
    chk({nm, " wr_addr"}, 32'(wr_addr_o), 32'd0);
    chk({nm, " wr_data"}, 32'(wr_data_o), 32'd0);
    chk({nm, " frame_valid"}, 32'(frame_valid_o), 32'd0);
    chk({nm, " rd_bank"}, 32'(rd_bank_o), 32'd0);
    chk({nm, " dropped"}, 32'(frames_dropped_o), 32'd0);
    chk({nm, " timeouts"}, 32'(timeouts_o), 32'd0);
  endtask

  initial begin
    logic [40:0] act, exp;

    // ---- build vector table ----
    cur_tag = "bringup";    seq_start();
    cur_tag = "pix 1234";   pix(4'h0, 16'h1234); idle(1'b0);
    cur_tag = "frame0";
    for (int p = 1; p < 8; p++) pix(4'(p), {8'(8'hA0 + p), 8'(p)});
    ex_fv = 1'b1; ex_rb = 1'b0; idle(1'b0);
    cur_tag = "frame1 drop";
    for (int p = 0; p < 8; p++) pix(4'(8 + p), {8'(8'hB0 + p), 8'(p)});
    ex_drop = 8'd1; idle(1'b0);
    cur_tag = "frame2 ack@commit";
    for (int p = 0; p < 8; p++) pix(4'(8 + p), {8'(8'hC0 + p), 8'(p)});
    ex_rb = 1'b1; idle(1'b1);
    cur_tag = "enable drop";
    pix(4'h0, 16'h5566); pix(4'h1, 16'h7788);
    add(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
    cur_tag = "re-enable";  seq_start(); pix(4'h0, 16'hDEAD);
    cur_tag = "ack";        ex_fv = 1'b0; idle(1'b1);
    cur_tag = "ack ignored"; idle(1'b1);
    cur_tag = "timeout";
    add(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 19; i++) idle(1'b0);
    ex_tmo = 8'd1; seq_start();
    cur_tag = "post timeout"; pix(4'h0, 16'hABCD);

    // ---- reset ----
    reset_ni = 1'b0; enable_i = 1'b0; mst_valid_i = 1'b0; mst_data_i = 8'h00; frame_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    reset_ni = 1'b1;

    // ---- apply table ----
    for (int i = 0; i < vecs.size(); i++) begin
      enable_i = vecs[i].en; mst_valid_i = vecs[i].vld;
      mst_data_i = vecs[i].dat; frame_ack_i = vecs[i].ack;
      @(posedge clk);
      #1;
      act = {mst_reset_o, mst_start_o, wr_en_o, frame_valid_o, rd_bank_o, frames_dropped_o,
             timeouts_o, vecs[i].we ? wr_addr_o : 4'h0, vecs[i].we ? wr_data_o : 16'h0};
      exp = {vecs[i].rst, vecs[i].st, vecs[i].we, vecs[i].fv, vecs[i].rb, vecs[i].drop,
             vecs[i].tmo, vecs[i].we ? vecs[i].addr : 4'h0, vecs[i].we ? vecs[i].wd : 16'h0};
      n_vec++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s vec %0d: got rst=%b st=%b we=%b fv=%b rb=%b drop=%0d tmo=%0d addr=%h data=%h; want rst=%b st=%b we=%b fv=%b rb=%b drop=%0d tmo=%0d addr=%h data=%h",
                 vecs[i].tag, i, act[40], act[39], act[38], act[37], act[36], act[35:28],
                 act[27:20], act[19:16], act[15:0], exp[40], exp[39], exp[38], exp[37],
                 exp[36], exp[35:28], exp[27:20], exp[19:16], exp[15:0]);
      end
    end

    // ---- asynchronous reset mid-pixel ----
    enable_i = 1'b1; mst_valid_i = 1'b1; mst_data_i = 8'h11; frame_ack_i = 1'b0;
    @(posedge clk);
    mst_valid_i = 1'b0;
    #2 reset_ni = 1'b0;
    #1 chk_reset_vals("async reset");
    @(posedge clk);
    #1 enable_i = 1'b0; reset_ni = 1'b1;
    @(posedge clk);
    #1 chk("idle after reset mst_reset", 32'(mst_reset_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
